// File: rtl/rv32i_types.sv
// Shared RV32I constants and types for the register file and its write scoreboard.
package rv32i_types;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;
    localparam int PEND_W_DEF = 2;

    typedef logic [PEND_W_DEF-1:0] pend_cnt_t;
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating increment and a decrement of up to two.
module sb_counter
    import rv32i_types::*;
#(
    parameter int W = $bits(pend_cnt_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic [1:0]   dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic [W+1:0] up;
    logic         inc_eff, underflow;

    assign full_o  = cnt_q == {W{1'b1}};
    assign empty_o = cnt_q == '0;
    assign cnt_o   = cnt_q;

    always_comb begin
        inc_eff   = inc_i && !full_o;
        up        = {2'b00, cnt_q} + {{(W+1){1'b0}}, inc_eff};
        underflow = up < {{W{1'b0}}, dec_i};
        cnt_d     = underflow ? '0 : W'(up - {{W{1'b0}}, dec_i});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Retiring more writes than were issued means the pipeline lost track of a destination.
    assert property (@(posedge clk) disable iff (rst) !underflow);
endmodule

// File: rtl/regfile_sb.sv
// RV32I architectural register file with writeback bypass, RAW scoreboard and retirement order counter.
module regfile_sb
    import rv32i_types::*;
#(
    parameter int PEND_W  = PEND_W_DEF,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               regf_we,
    input  logic [4:0]         rd_s_wb,
    input  logic [31:0]        rd_v_wb,
    input  logic               commit,
    input  logic [4:0]         rs1_s,
    input  logic [4:0]         rs2_s,
    input  logic               rs1_use,
    input  logic               rs2_use,
    output logic [31:0]        rs1_v,
    output logic [31:0]        rs2_v,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    input  logic               kill_valid,
    input  logic [4:0]         kill_rd,
    output logic               raw_stall,
    output logic               issue_full,
    output logic [ORDER_W-1:0] order
);
    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [PEND_W-1:0]   pend   [NUM_REGS];
    logic [NUM_REGS-1:0] full_v;
    logic [NUM_REGS-1:0] empty_v;
    logic [ORDER_W-1:0]  order_q, order_d;
    logic                hit1, hit2, stall1, stall2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (regf_we && rd_s_wb != '0) begin
            regs_q[rd_s_wb] <= rd_v_wb;
        end
    end

    assign pend[0]    = '0;
    assign full_v[0]  = 1'b0;
    assign empty_v[0] = 1'b1;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        logic       inc;
        logic [1:0] dec;

        assign inc = issue_valid && issue_rd == 5'(r);
        assign dec = {1'b0, regf_we && rd_s_wb == 5'(r)} + {1'b0, kill_valid && kill_rd == 5'(r)};

        sb_counter #(.W(PEND_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (inc),
            .dec_i   (dec),
            .cnt_o   (pend[r]),
            .full_o  (full_v[r]),
            .empty_o (empty_v[r])
        );
    end

    always_comb begin
        hit1  = regf_we && rd_s_wb == rs1_s;
        hit2  = regf_we && rd_s_wb == rs2_s;
        rs1_v = '0;
        rs2_v = '0;
        if (rs1_s != '0) rs1_v = hit1 ? rd_v_wb : regs_q[rs1_s];
        if (rs2_s != '0) rs2_v = hit2 ? rd_v_wb : regs_q[rs2_s];
        // A single outstanding write that lands this cycle is covered by the bypass path.
        stall1 = rs1_use && rs1_s != '0 && !empty_v[rs1_s] && !(hit1 && pend[rs1_s] == PEND_W'(1));
        stall2 = rs2_use && rs2_s != '0 && !empty_v[rs2_s] && !(hit2 && pend[rs2_s] == PEND_W'(1));
        raw_stall  = stall1 || stall2;
        issue_full = issue_rd != '0 && full_v[issue_rd];
    end

    assign order_d = order_q + {{(ORDER_W-1){1'b0}}, commit};
    assign order   = order_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_q <= '0;
        end else begin
            order_q <= order_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(issue_valid && issue_full));
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations plus random traffic against a behavioural model.
module tb_regfile_sb;
    localparam int PEND_W = 2;
    localparam int PMAX   = (1 << PEND_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        regf_we;
    logic [4:0]  rd_s_wb;
    logic [31:0] rd_v_wb;
    logic        commit;
    logic [4:0]  rs1_s, rs2_s;
    logic        rs1_use, rs2_use;
    logic [31:0] rs1_v, rs2_v;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic        raw_stall, issue_full;
    logic [63:0] order;

    int errors = 0;
    int checks = 0;

    logic [31:0]     m_regs [32];
    int              m_pend [32];
    longint unsigned m_order;

    always #5 clk = ~clk;

    regfile_sb #(.PEND_W(PEND_W), .ORDER_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .regf_we     (regf_we),
        .rd_s_wb     (rd_s_wb),
        .rd_v_wb     (rd_v_wb),
        .commit      (commit),
        .rs1_s       (rs1_s),
        .rs2_s       (rs2_s),
        .rs1_use     (rs1_use),
        .rs2_use     (rs2_use),
        .rs1_v       (rs1_v),
        .rs2_v       (rs2_v),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .kill_valid  (kill_valid),
        .kill_rd     (kill_rd),
        .raw_stall   (raw_stall),
        .issue_full  (issue_full),
        .order       (order)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: plain array of values, pending-write counts and a retire count.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
            m_order = 0;
        end else begin
            if (issue_valid && issue_rd != 0 && m_pend[issue_rd] < PMAX) m_pend[issue_rd]++;
            if (regf_we && rd_s_wb != 0) begin
                m_regs[rd_s_wb] = rd_v_wb;
                m_pend[rd_s_wb]--;
            end
            if (kill_valid && kill_rd != 0) m_pend[kill_rd]--;
            if (commit) m_order++;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] s);
        if (s == 0) return 32'h0;
        if (regf_we && rd_s_wb == s) return rd_v_wb;
        return m_regs[s];
    endfunction

    function automatic bit exp_stall(input logic u, input logic [4:0] s);
        if (!u || s == 0) return 1'b0;
        return (m_pend[s] - ((regf_we && rd_s_wb == s) ? 1 : 0)) != 0;
    endfunction

    always @(negedge clk) begin
        chk("rs1_v", rs1_v, exp_rd(rs1_s));
        chk("rs2_v", rs2_v, exp_rd(rs2_s));
        chk("raw_stall", raw_stall, exp_stall(rs1_use, rs1_s) || exp_stall(rs2_use, rs2_s));
        chk("issue_full", issue_full, issue_rd != 0 && m_pend[issue_rd] == PMAX);
        chk("order", order, m_order);
    end

    task automatic idle();
        regf_we = 0; rd_s_wb = 0; rd_v_wb = 0; commit = 0;
        rs1_s = 0; rs2_s = 0; rs1_use = 0; rs2_use = 0;
        issue_valid = 0; issue_rd = 0; kill_valid = 0; kill_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_pend();
        for (int t = 0; t < 8; t++) begin
            int r;
            r = $urandom_range(1, 15);
            if (m_pend[r] > 0) return r;
        end
        return 0;
    endfunction

    task automatic rand_cycle();
        int r;
        idle();
        r = pick_pend();
        if (r != 0 && $urandom_range(0, 3) != 0) begin
            regf_we = 1; rd_s_wb = 5'(r); rd_v_wb = $urandom;
        end else if ($urandom_range(0, 5) == 0) begin
            regf_we = 1; rd_s_wb = 0; rd_v_wb = $urandom;
        end
        commit = regf_we ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
        r = $urandom_range(1, 15);
        if ($urandom_range(0, 4) == 0 && (m_pend[r] - ((regf_we && rd_s_wb == r) ? 1 : 0)) > 0) begin
            kill_valid = 1; kill_rd = 5'(r);
        end
        r = $urandom_range(0, 15);
        issue_rd    = 5'(r);
        issue_valid = (m_pend[r] < PMAX) && ($urandom_range(0, 1) == 1);
        rs1_s   = 5'($urandom_range(0, 15));
        rs2_s   = 5'($urandom_range(0, 15));
        rs1_use = 1'($urandom_range(0, 1));
        rs2_use = 1'($urandom_range(0, 1));
    endtask

    // Scenario table for the x3 sequence: issue, kill, writeback, expected stall on rs1=x3.
    bit t_iss [7] = '{1, 1, 0, 1, 0, 0, 0};
    bit t_kil [7] = '{0, 0, 1, 0, 0, 0, 0};
    bit t_wb  [7] = '{0, 0, 0, 1, 0, 1, 0};
    bit t_stl [7] = '{0, 1, 1, 0, 1, 0, 0};
    bit t_we  [5] = '{1, 0, 1, 0, 1};

    initial begin
        idle();
        #2 rst = 1;
        #1;
        rs1_s = 3; rs2_s = 4; rs1_use = 1; issue_rd = 9;
        #1;
        chk("reset_rs1", rs1_v, 0);
        chk("reset_rs2", rs2_v, 0);
        chk("reset_raw", raw_stall, 0);
        chk("reset_full", issue_full, 0);
        chk("reset_order", order, 0);
        @(negedge clk);
        #2 rst = 0;

        for (int s = 0; s < 32; s++) begin
            idle();
            rs1_s = 5'(s); rs2_s = 5'(31 - s);
            #1;
            chk("reset_read1", rs1_v, 0);
            chk("reset_read2", rs2_v, 0);
            tick();
        end

        idle();
        regf_we = 1; rd_s_wb = 0; rd_v_wb = 32'hDEADBEEF;
        #1 chk("x0_write_bypass", rs1_v, 0);
        tick();
        idle();
        #1 chk("x0_read", rs1_v, 0);
        tick();

        idle(); issue_valid = 1; issue_rd = 5;
        tick();
        idle(); regf_we = 1; rd_s_wb = 5; rd_v_wb = 32'h12345678; rs1_s = 5;
        #1 chk("bypass_x5", rs1_v, 32'h12345678);
        tick();
        idle(); rs1_s = 5;
        #1 chk("array_x5", rs1_v, 32'h12345678);
        tick();

        idle(); issue_valid = 1; issue_rd = 7;
        tick();
        idle(); rs2_s = 7; rs2_use = 1;
        #1 chk("raw_x7_pending", raw_stall, 1);
        tick();
        idle(); rs2_s = 7; rs2_use = 1; regf_we = 1; rd_s_wb = 7; rd_v_wb = 32'h77;
        #1 chk("raw_x7_bypass", raw_stall, 0);
        chk("raw_x7_value", rs2_v, 32'h77);
        tick();
        idle(); rs2_s = 7; rs2_use = 1;
        #1 chk("raw_x7_clear", raw_stall, 0);
        tick();

        for (int k = 0; k < 7; k++) begin
            idle();
            rs1_s = 3; rs1_use = 1;
            if (t_iss[k]) begin issue_valid = 1; issue_rd = 3; end
            if (t_kil[k]) begin kill_valid = 1; kill_rd = 3; end
            if (t_wb[k]) begin regf_we = 1; rd_s_wb = 3; rd_v_wb = 32'h3300 + 32'(k); end
            #1 chk("raw_x3_seq", raw_stall, t_stl[k]);
            tick();
        end
        idle(); rs1_s = 3;
        #1 chk("x3_final_value", rs1_v, 32'h3305);
        tick();

        for (int k = 0; k < 3; k++) begin
            idle(); issue_valid = 1; issue_rd = 9;
            #1 chk("x9_not_full", issue_full, 0);
            tick();
        end
        idle(); issue_rd = 9;
        #1 chk("x9_full", issue_full, 1);
        issue_rd = 0;
        #1 chk("x0_never_full", issue_full, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(); regf_we = 1; rd_s_wb = 9; rd_v_wb = 32'h900 + 32'(k);
            tick();
        end
        idle(); issue_rd = 9;
        #1 chk("x9_drained", issue_full, 0);
        tick();

        for (int k = 0; k < 5; k++) begin
            idle(); commit = 1; regf_we = t_we[k]; rd_s_wb = 0; rd_v_wb = 32'hC0 + 32'(k);
            #1 chk("order_seq", order, 64'(k));
            tick();
        end
        idle();
        #1 chk("order_after5", order, 5);
        tick();

        for (int n = 0; n < 3000; n++) begin
            rand_cycle();
            tick();
        end

        idle(); issue_valid = 1; issue_rd = 20;
        tick();
        idle(); issue_valid = 1; issue_rd = 21; regf_we = 1; rd_s_wb = 20; rd_v_wb = 32'hA5A50001;
        tick();
        idle(); rs1_s = 21; rs1_use = 1; rs2_s = 20; issue_rd = 21;
        #1 chk("pre_rst_raw", raw_stall, 1);
        chk("pre_rst_rs2", rs2_v, 32'hA5A50001);
        #1 rst = 1;
        #1;
        chk("async_rst_order", order, 0);
        chk("async_rst_raw", raw_stall, 0);
        chk("async_rst_rs2", rs2_v, 0);
        chk("async_rst_full", issue_full, 0);
        @(negedge clk);
        #2 rst = 0;
        #1;
        for (int n = 0; n < 200; n++) begin
            rand_cycle();
            tick();
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
